uart_reg_writer: RTL and testbench

- Parametrised successor to the UART-addressed memory controller.
- Decodes a byte stream from the UART receiver into register-file write transactions: address byte, then DATA_BYTES data bytes, big-endian.
- A reserved sync byte re-aligns the stream at any point, and an inter-byte timeout aborts stalled frames.
- Sits between the UART receiver and the PID coefficient/setpoint register file.

---
 rtl/reg_writer_pkg.sv | 18 +
 rtl/rdy_edge_sync.sv | 34 +++
 rtl/uart_reg_writer.sv | 190 +++++++++++++++++++
 tb/tb_uart_reg_writer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_writer_pkg.sv
// Shared types and constants for the UART register writer.
// Optional checksum stage is enabled with REG_WRITER_CHKSUM_EN.
package reg_writer_pkg;

  typedef enum logic [1:0] {
    S_ADDR   = 2'd0,
    S_DATA   = 2'd1,
    S_CHK    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hFF;

  function automatic int unsigned data_w(input int unsigned n_bytes);
    return 8 * n_bytes;
  endfunction

endpackage

// File: rtl/rdy_edge_sync.sv
// Registers the UART byte-valid level and emits one registered accept pulse
// per rising edge, capturing the byte alongside it.
module rdy_edge_sync (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rdy,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic [7:0] o_byte
);

  logic       r_rdy_q;
  logic       r_accept;
  logic [7:0] r_byte;
  logic       w_rise;

  assign w_rise = i_rdy & ~r_rdy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy_q  <= 1'b0;
      r_accept <= 1'b0;
      r_byte   <= '0;
    end else begin
      r_rdy_q  <= i_rdy;
      r_accept <= w_rise;
      if (w_rise) r_byte <= i_data;
    end
  end

  assign o_accept = r_accept;
  assign o_byte   = r_byte;

endmodule

// File: rtl/uart_reg_writer.sv
// Decodes a UART byte stream (address, then DATA_BYTES big-endian data bytes)
// into register-file writes. Define REG_WRITER_CHKSUM_EN for a trailing XOR checksum byte.
module uart_reg_writer
  import reg_writer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_BYTES  = 2,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    data_rdy,
  input  logic [7:0]              data_in,
  output logic                    write_enable,
  output logic [ADDR_W-1:0]       addr,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    frame_err
);

  localparam int unsigned DW    = data_w(DATA_BYTES);
  localparam int unsigned CNT_W = 2;

  logic             w_accept;
  logic [7:0]       w_byte;

  state_t           r_state,  w_state_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [DW-1:0]    r_stage,  w_stage_nxt;
  logic [DW-1:0]    r_dout,   w_dout_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [15:0]      r_tmo,    w_tmo_nxt;
  logic             r_we,     w_we_nxt;
  logic             r_err,    w_err_nxt;
  logic             r_pend,   w_pend_nxt;
`ifdef REG_WRITER_CHKSUM_EN
  logic [7:0]       r_chk,    w_chk_nxt;
`endif

  logic             w_acc;
  logic             w_addr_ok;
  logic [15:0]      w_tmo_inc;
  logic             w_tmo_hit;

  rdy_edge_sync u_edge (
    .i_clk    (clk_in),
    .i_rst    (reset),
    .i_rdy    (data_rdy),
    .i_data   (data_in),
    .o_accept (w_accept),
    .o_byte   (w_byte)
  );

  // An accept arriving during S_COMMIT is held one cycle and replayed in S_ADDR.
  assign w_acc     = w_accept | r_pend;
  assign w_addr_ok = {1'b0, w_byte} < (9'd1 << ADDR_W);
  assign w_tmo_inc = r_tmo + 16'd1;
  assign w_tmo_hit = (TIMEOUT_CYC != 16'd0) && (w_tmo_inc == TIMEOUT_CYC);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_stage_nxt = r_stage;
    w_dout_nxt  = r_dout;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_we_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_pend_nxt  = 1'b0;
`ifdef REG_WRITER_CHKSUM_EN
    w_chk_nxt   = r_chk;
`endif
    if (r_state == S_COMMIT) begin
      w_dout_nxt  = r_stage;
      w_we_nxt    = 1'b1;
      w_tmo_nxt   = '0;
      w_pend_nxt  = w_acc;
      w_state_nxt = S_ADDR;
    end else if (w_acc && (w_byte == SYNC_BYTE)) begin
      w_err_nxt   = (r_state != S_ADDR);
      w_cnt_nxt   = '0;
      w_tmo_nxt   = '0;
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR: begin
          w_tmo_nxt = '0;
          if (w_acc) begin
            if (w_addr_ok) begin
              w_addr_nxt  = w_byte[ADDR_W-1:0];
              w_cnt_nxt   = '0;
              w_stage_nxt = '0;
`ifdef REG_WRITER_CHKSUM_EN
              w_chk_nxt   = w_byte;
`endif
              w_state_nxt = S_DATA;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            w_tmo_nxt   = '0;
            w_stage_nxt = (r_stage << 8) | DW'(w_byte);
`ifdef REG_WRITER_CHKSUM_EN
            w_chk_nxt   = r_chk ^ w_byte;
`endif
            if (r_cnt == CNT_W'(DATA_BYTES - 1)) begin
              w_cnt_nxt = '0;
`ifdef REG_WRITER_CHKSUM_EN
              w_state_nxt = S_CHK;
`else
              w_state_nxt = S_COMMIT;
`endif
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else if (w_tmo_hit) begin
            w_err_nxt   = 1'b1;
            w_stage_nxt = '0;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = S_ADDR;
          end else begin
            w_tmo_nxt = w_tmo_inc;
          end
        end
`ifdef REG_WRITER_CHKSUM_EN
        S_CHK: begin
          if (w_acc) begin
            w_tmo_nxt = '0;
            if (w_byte == r_chk) begin
              w_state_nxt = S_COMMIT;
            end else begin
              w_err_nxt   = 1'b1;
              w_stage_nxt = '0;
              w_state_nxt = S_ADDR;
            end
          end else if (w_tmo_hit) begin
            w_err_nxt   = 1'b1;
            w_stage_nxt = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = S_ADDR;
          end else begin
            w_tmo_nxt = w_tmo_inc;
          end
        end
`endif
        default: w_state_nxt = S_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_ADDR;
      r_addr  <= '0;
      r_stage <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_pend  <= 1'b0;
`ifdef REG_WRITER_CHKSUM_EN
      r_chk   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_stage <= w_stage_nxt;
      r_dout  <= w_dout_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_we    <= w_we_nxt;
      r_err   <= w_err_nxt;
      r_pend  <= w_pend_nxt;
`ifdef REG_WRITER_CHKSUM_EN
      r_chk   <= w_chk_nxt;
`endif
    end
  end

  assign write_enable = r_we;
  assign frame_err    = r_err;
  assign addr         = r_addr;
  assign data_out     = r_dout;

endmodule

// File: tb/tb_uart_reg_writer.sv
// Scoreboard bench for uart_reg_writer (ADDR_W=5, DATA_BYTES=2, TIMEOUT_CYC=100).
module tb_uart_reg_writer;

  typedef struct packed {
    logic        is_err;
    logic [4:0]  a;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_rdy;
  logic [7:0]  data_in;
  logic        write_enable;
  logic [4:0]  addr;
  logic [15:0] data_out;
  logic        frame_err;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  uart_reg_writer #(
    .ADDR_W      (5),
    .DATA_BYTES  (2),
    .SYNC_BYTE   (8'hFF),
    .TIMEOUT_CYC (16'd100)
  ) dut (
    .clk_in       (clk),
    .reset        (reset),
    .data_rdy     (data_rdy),
    .data_in      (data_in),
    .write_enable (write_enable),
    .addr         (addr),
    .data_out     (data_out),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: every output event is matched against the oldest expectation.
  always @(negedge clk) begin
    if (write_enable || frame_err) begin
      exp_t e;
      checks++;
      if (write_enable && frame_err) begin
        errors++;
        $display("FAIL both_strobes: write_enable=%0b frame_err=%0b, required not both", write_enable, frame_err);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: we=%0b err=%0b addr=%0h data=%0h, required no event",
                 write_enable, frame_err, addr, data_out);
      end else begin
        e = q.pop_front();
        if (e.is_err) begin
          if (!frame_err) begin
            errors++;
            $display("FAIL event_kind: got write addr=%0h data=%0h, required frame_err", addr, data_out);
          end
        end else if (!write_enable || addr !== e.a || data_out !== e.d) begin
          errors++;
          $display("FAIL write: we=%0b addr=%0h data=%0h, required addr=%0h data=%0h",
                   write_enable, addr, data_out, e.a, e.d);
        end
      end
    end
  end

  task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    e.is_err = 1'b0; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.a = '0; e.d = '0;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    data_in  = b;
    data_rdy = 1'b1;
    repeat (hold) @(negedge clk);
    data_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input int hold);
    send_byte(a, hold);
    send_byte(d[15:8], hold);
    send_byte(d[7:0], hold);
`ifdef REG_WRITER_CHKSUM_EN
    send_byte(a ^ d[15:8] ^ d[7:0], hold);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (write_enable !== 1'b0 || frame_err !== 1'b0 || addr !== 5'h0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL %s: we=%0b err=%0b addr=%0h data=%0h, required all 0",
               tag, write_enable, frame_err, addr, data_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] last_b;
    reset = 1'b1; data_rdy = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");

    // Basic frame with latency measurement on the final byte.
    push_wr(5'd3, 16'h1234);
    send_byte(8'h03, 1);
    send_byte(8'h12, 1);
`ifdef REG_WRITER_CHKSUM_EN
    send_byte(8'h34, 1);
    last_b = 8'h25;
`else
    last_b = 8'h34;
`endif
    @(negedge clk);
    data_in = last_b; data_rdy = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) data_rdy = 1'b0;
      if (write_enable) begin n = i; break; end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL write_latency: edge index %0d, required 3 (2 cycles after sampling edge)", n);
    end
    repeat (3) @(negedge clk);

    // Sync mid-frame, then a clean frame.
    push_err();
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    send_byte(8'hFF, 1);
    push_wr(5'd4, 16'hABCD);
    send_frame(8'h04, 16'hABCD, 1);

    // Sync while idle is silent.
    send_byte(8'hFF, 1);

    // Out-of-range address, then recovery.
    push_err();
    send_byte(8'h20, 1);
    push_wr(5'd1, 16'h0007);
    send_frame(8'h01, 16'h0007, 3);

    // Highest valid address.
    push_wr(5'd31, 16'h8001);
    send_frame(8'h1F, 16'h8001, 1);

    // Inter-byte timeout.
    push_err();
    send_byte(8'h05, 1);
    @(negedge clk);
    data_in = 8'h66; data_rdy = 1'b1;
    n = 0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      if (i == 1) data_rdy = 1'b0;
      if (frame_err && n == 0) n = i;
    end
    checks++;
    if (n < 100 || n > 103) begin
      errors++;
      $display("FAIL timeout_delay: frame_err at edge %0d, required 100..103", n);
    end
    push_wr(5'd6, 16'h1357);
    send_frame(8'h06, 16'h1357, 1);

    // Long data_rdy levels with a reset mid-frame.
    send_byte(8'h07, 40);
    send_byte(8'h55, 40);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_frame_reset");
    push_wr(5'd9, 16'hBEEF);
    send_frame(8'h09, 16'hBEEF, 40);

`ifdef REG_WRITER_CHKSUM_EN
    push_wr(5'd3, 16'h1234);
    send_byte(8'h03, 1); send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h25, 1);
    push_err();
    send_byte(8'h03, 1); send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h26, 1);
`endif

    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expect: %0d events never seen, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
